conv2_layer_sequencer: RTL and testbench

CONV2_LAYER_SEQUENCER -- requirements
Module: conv2_layer_sequencer

---
 rtl/conv2_pkg.sv | 28 ++
 rtl/wrap_counter.sv | 38 +++
 rtl/conv2_layer_sequencer.sv | 130 +++++++++++++
 tb/tb_conv2_layer_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// conv2_pkg -- shared definitions for the conv2 layer sequencer.
//   TAPS     : kernel taps per output pixel (5x5 kernel)
//   PIXELS   : output pixels per channel (8x8 image)
//   CHANNELS : output channels
//   PIPE_LAT : MAC pipeline cycles from the last mac_en to a valid result
//   state_e  : sequencer FSM state encoding
package conv2_pkg;

  localparam int TAPS     = 25;
  localparam int PIXELS   = 64;
  localparam int CHANNELS = 3;
  localparam int PIPE_LAT = 2;

  localparam int TAP_W   = 5;
  localparam int PIX_W   = 6;
  localparam int CHAN_W  = 2;
  localparam int DRAIN_W = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    MAC    = 3'd2,
    DRAIN  = 3'd3,
    WRITE  = 3'd4,
    FINISH = 3'd5
  } state_e;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter -- saturating up-counter with synchronous clear.
//   clk    : clock
//   inc    : advance by one (ignored once value has reached MAX_VAL)
//   clr    : synchronous clear to 0, wins over inc
//   value  : current count
//   at_max : value == MAX_VAL
// The count never wraps; the owner decides when to clear it.
module wrap_counter #(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 24
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             at_max
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  assign at_max = (value_q == WIDTH'(MAX_VAL));
  assign value  = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && !at_max) begin
      value_d = value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    value_q <= value_d;
  end

endmodule

// File: rtl/conv2_layer_sequencer.sv
// conv2_layer_sequencer -- steps a MAC unit through one full conv2 layer:
// for every channel (0..2) and every output pixel (0..63) it clears the
// accumulator, feeds 25 kernel taps, waits out the MAC pipeline and writes
// the result.
//   clk       : clock, all state updates on posedge
//   reset     : synchronous active-high reset
//   start     : run one layer; only looked at in IDLE
//   stall     : operands not ready; freezes the MAC phase
//   mac_clear : clear accumulator (one cycle per pixel)
//   mac_en    : accumulate current tap
//   tap       : kernel tap index 0..24
//   wr_en     : write MAC result to the output memory
//   wr_addr   : output pixel address 0..63 (held between writes)
//   wr_chan   : output channel 0..2 (held between writes)
//   busy      : high whenever not IDLE
//   done      : one-cycle pulse at layer completion
// Handshake: stall is a plain level "not ready"; while it is high in MAC no
// tap is consumed (mac_en low, tap held). It has no effect in other states.
module conv2_layer_sequencer
  import conv2_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              mac_clear,
  output logic              mac_en,
  output logic [TAP_W-1:0]  tap,
  output logic              wr_en,
  output logic [PIX_W-1:0]  wr_addr,
  output logic [CHAN_W-1:0] wr_chan,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;

  logic              tap_inc, tap_clr, tap_max;
  logic              pix_inc, pix_clr, pix_max;
  logic              chan_inc, chan_clr, chan_max;
  logic [TAP_W-1:0]  tap_val;
  logic [PIX_W-1:0]  pix_val;
  logic [CHAN_W-1:0] chan_val;

  logic in_idle, in_mac, in_write, in_finish, launch, tap_step;

  assign in_idle   = (state_q == IDLE);
  assign in_mac    = (state_q == MAC);
  assign in_write  = (state_q == WRITE);
  assign in_finish = (state_q == FINISH);
  assign launch    = in_idle && start;
  assign tap_step  = in_mac && !stall;

  // Tap is cleared as MAC is left, so it reads 0 in every other state.
  assign tap_inc  = tap_step && !tap_max;
  assign tap_clr  = reset || (tap_step && tap_max);

  // Pixel/channel are cleared on launch and after FINISH so IDLE shows 0.
  assign pix_inc  = in_write && !pix_max;
  assign pix_clr  = reset || launch || in_finish || (in_write && pix_max && !chan_max);
  assign chan_inc = in_write && pix_max && !chan_max;
  assign chan_clr = reset || launch || in_finish;

  wrap_counter #(.WIDTH(TAP_W), .MAX_VAL(TAPS - 1)) u_tap_cnt (
    .clk    (clk),
    .inc    (tap_inc),
    .clr    (tap_clr),
    .value  (tap_val),
    .at_max (tap_max)
  );

  wrap_counter #(.WIDTH(PIX_W), .MAX_VAL(PIXELS - 1)) u_pix_cnt (
    .clk    (clk),
    .inc    (pix_inc),
    .clr    (pix_clr),
    .value  (pix_val),
    .at_max (pix_max)
  );

  wrap_counter #(.WIDTH(CHAN_W), .MAX_VAL(CHANNELS - 1)) u_chan_cnt (
    .clk    (clk),
    .inc    (chan_inc),
    .clr    (chan_clr),
    .value  (chan_val),
    .at_max (chan_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = '0;
    unique case (state_q)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR:  state_d = MAC;
      MAC:    if (tap_step && tap_max) state_d = DRAIN;
      DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
          state_d = WRITE;
          drain_d = '0;
        end
      end
      WRITE:  state_d = (pix_max && chan_max) ? FINISH : CLEAR;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mac_en is gated directly by stall so no tap is consumed in a stalled
  // cycle; everything else is a pure decode of state and counters.
  assign mac_clear = (state_q == CLEAR);
  assign mac_en    = tap_step;
  assign tap       = tap_val;
  assign wr_en     = in_write;
  assign wr_addr   = pix_val;
  assign wr_chan   = chan_val;
  assign busy      = !in_idle;
  assign done      = in_finish;

endmodule

// File: tb/tb_conv2_layer_sequencer.sv
module tb_conv2_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stall;
  logic       mac_clear, mac_en, wr_en, busy, done;
  logic [4:0] tap;
  logic [5:0] wr_addr;
  logic [1:0] wr_chan;

  conv2_layer_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .mac_clear (mac_clear),
    .mac_en    (mac_en),
    .tap       (tap),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_chan   (wr_chan),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned t0 = 0;          // cyc value in the cycle start was sampled
  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  bit          mon_en   = 1'b0;

  // expected write: {relative cycle[15:0], chan[1:0], addr[5:0]}
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;
  logic [23:0] mon_obs;
  int unsigned mon_rel;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc - t0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check_eq("wr_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_rel = cyc - t0;
          mon_exp = exp_q.pop_front();
          mon_obs = {mon_rel[15:0], wr_chan, wr_addr};
          check_eq("wr_seq", {8'd0, mon_obs}, {8'd0, mon_exp});
        end
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_rel(input int unsigned r);
    while ((cyc - t0) < r) @(negedge clk);
  endtask

  // Pushes the full 192-write sequence; delay shifts every write.
  task automatic push_run(input int delay);
    logic [15:0] rel;
    logic [1:0]  c;
    logic [5:0]  a;
    for (int k = 0; k < 192; k++) begin
      rel = 16'(29 + 29 * k + delay);
      c   = 2'(k / 64);
      a   = 6'(k % 64);
      exp_q.push_back({rel, c, a});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic begin_run();
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {14'd0, busy, done, mac_clear, mac_en, wr_en, tap, wr_addr, wr_chan};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("reset_outs", all_outs(), 32'd0);
    mon_en = 1'b1;

    // Run 1: no stall, full layer
    push_run(0);
    begin_run();
    check_eq("clr_pulse", {30'd0, mac_clear, busy}, 32'd3);
    check_eq("clr_tap", 32'(tap), 32'd0);
    for (int r = 2; r <= 26; r++) begin
      wait_rel(r);
      check_eq("mac_tap", {26'd0, mac_en, mac_clear, tap}, {26'd0, 1'b1, 1'b0, 5'(r - 2)});
    end
    wait_rel(27);
    check_eq("drain_outs", {24'd0, mac_clear, mac_en, wr_en, tap}, 32'd0);
    wait_rel(5568);
    check_eq("pre_done", 32'(done), 32'd0);
    wait_rel(5569);
    check_eq("done_pulse", {30'd0, done, busy}, 32'd3);
    wait_rel(5570);
    check_eq("idle_after", all_outs(), 32'd0);
    wait_rel(5571);
    check_eq("run1_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("run1_done_cnt", 32'(done_cnt), 32'd1);

    // Run 2: 3-cycle stall at tap 10, start pulses mid-run and in FINISH
    push_run(3);
    begin_run();
    wait_rel(12);
    check_eq("pre_stall", {27'd0, mac_en, tap}, {27'd0, 1'b1, 5'd10});
    stall = 1'b1;
    #1 check_eq("stall_0", {27'd0, mac_en, tap}, {27'd0, 1'b0, 5'd10});
    wait_rel(13);
    check_eq("stall_1", {27'd0, mac_en, tap}, {27'd0, 1'b0, 5'd10});
    wait_rel(14);
    check_eq("stall_2", {27'd0, mac_en, tap}, {27'd0, 1'b0, 5'd10});
    wait_rel(15);
    stall = 1'b0;
    #1 check_eq("unstall", {27'd0, mac_en, tap}, {27'd0, 1'b1, 5'd10});
    wait_rel(16);
    check_eq("tap_resume", 32'(tap), 32'd11);
    wait_rel(1000);
    start = 1'b1;
    wait_rel(1001);
    start = 1'b0;
    check_eq("midrun_busy", 32'(busy), 32'd1);
    wait_rel(5572);
    check_eq("run2_done", 32'(done), 32'd1);
    start = 1'b1;               // held through FINISH into first IDLE cycle
    wait_rel(5573);
    check_eq("finish_start_ign", {30'd0, busy, mac_clear}, 32'd0);
    check_eq("run2_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("run2_done_cnt", 32'(done_cnt), 32'd2);

    // Run 3: started in the first IDLE cycle after FINISH, reset mid-run
    push_run(0);
    begin_run();
    check_eq("run3_clear", {28'd0, mac_clear, busy, wr_chan}, {28'd0, 1'b1, 1'b1, 2'd0});
    check_eq("run3_addr", 32'(wr_addr), 32'd0);
    wait_rel(29 * 84 + 10);
    check_eq("pre_reset_pos", {24'd0, mac_en, wr_chan, tap[0], wr_addr},
             {24'd0, 1'b1, 2'd1, 1'b0, 6'd20});
    check_eq("pre_reset_tap", 32'(tap), 32'd8);
    dc = done_cnt;
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("reset_mid_outs", all_outs(), 32'd0);
    repeat (100) @(negedge clk);
    check_eq("no_done_after_rst", 32'(done_cnt), 32'(dc));
    check_eq("idle_hold", all_outs(), 32'd0);

    // Run 4: restart from chan 0 pixel 0, a few pixels then reset
    push_run(0);
    begin_run();
    check_eq("run4_clear", {28'd0, mac_clear, busy, wr_chan}, {28'd0, 1'b1, 1'b1, 2'd0});
    wait_rel(29 * 3 + 1);
    check_eq("run4_q_left", 32'(exp_q.size()), 32'd189);
    do_reset();
    exp_q.delete();
    check_eq("final_outs", all_outs(), 32'd0);
    check_eq("final_done_cnt", 32'(done_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #400000;
    $display("FAIL timeout: cycle %0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
